// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and adaptor line ports seen by the arbiter.
// master = arbiter side, slave = caches/adaptor side.
interface cache_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache, one transaction at a time.
// D-cache has priority; after MAX_D_STREAK D grants with I waiting, the next grant goes to I.
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic             clk,
  input logic             rst,
  cache_mem_arbiter_if.master bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     streak, streak_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic              d_pend;
  logic              i_forced;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      streak  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    d_pend     = bus.dcache_read | bus.dcache_write;
    i_forced   = bus.icache_read && (streak == STREAK_MAX);
    case (state)
      IDLE: begin
        if (d_pend && !i_forced) begin
          addr_nxt = bus.dcache_address;
          if (bus.dcache_write) begin
            state_nxt = SERVE_D_WR;
            wdata_nxt = bus.dcache_wdata;
          end else begin
            state_nxt = SERVE_D_RD;
          end
          // Streak only grows while I is actually being held off.
          if (bus.icache_read)
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
          else
            streak_nxt = '0;
        end else if (bus.icache_read) begin
          state_nxt  = SERVE_I;
          addr_nxt   = bus.icache_address;
          streak_nxt = '0;
        end
      end
      default: begin
        if (bus.mem_resp)
          state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_read    = (state == SERVE_I) || (state == SERVE_D_RD);
  assign bus.mem_write   = (state == SERVE_D_WR);
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

  // Completion is forwarded the same cycle; a resp seen in IDLE is dropped.
  assign bus.icache_resp  = (state == SERVE_I) && bus.mem_resp;
  assign bus.dcache_resp  = ((state == SERVE_D_RD) || (state == SERVE_D_WR)) && bus.mem_resp;
  assign bus.icache_rdata = bus.icache_resp ? bus.mem_rdata : '0;
  assign bus.dcache_rdata = bus.dcache_resp ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grants, priority/starvation, latching, reset, spurious resp.
module tb_cache_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

  cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32), .MAX_D_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes one read grant: expects the given side and address, returns rd as line data.
  task automatic serve(input string tag, input bit exp_i, input logic [31:0] exp_addr,
                       input logic [255:0] rd);
    tick();
    check({tag, "_rd"}, bus.mem_read, 1'b1);
    check({tag, "_wr"}, bus.mem_write, 1'b0);
    check({tag, "_addr"}, bus.mem_address, exp_addr);
    bus.mem_rdata = rd;
    bus.mem_resp  = 1'b1;
    #1;
    check({tag, "_iresp"}, bus.icache_resp, exp_i);
    check({tag, "_dresp"}, bus.dcache_resp, !exp_i);
    if (exp_i) check({tag, "_irdata"}, bus.icache_rdata, rd);
    else       check({tag, "_drdata"}, bus.dcache_rdata, rd);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    check({tag, "_idle"}, bus.mem_read, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w1, w2, w3, rd;
    bus.icache_read = 0; bus.icache_address = '0;
    bus.dcache_read = 0; bus.dcache_write = 0;
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;
    w1 = {8{32'h1111_2222}};
    w2 = {8{32'hDEAD_BEEF}};
    w3 = {8{32'h0BAD_F00D}};

    // Reset state
    tick(); tick();
    check("rst_rd", bus.mem_read, 1'b0);
    check("rst_wr", bus.mem_write, 1'b0);
    check("rst_addr", bus.mem_address, 32'h0);
    check("rst_wdata", bus.mem_wdata, 256'h0);
    check("rst_streak", dut.streak, 0);

    // 1. I-only read, memory responds at cycle 10
    rst = 1'b1;
    bus.icache_read = 1; bus.icache_address = 32'h0000_0060;
    #1;
    check("t1_c0_rd", bus.mem_read, 1'b0);
    tick();
    for (int c = 1; c < 10; c++) begin
      check("t1_rd", bus.mem_read, 1'b1);
      check("t1_iresp", bus.icache_resp, 1'b0);
      tick();
    end
    check("t1_addr", bus.mem_address, 32'h60);
    rd = {8{32'hCAFE_0060}};
    bus.mem_rdata = rd; bus.mem_resp = 1;
    #1;
    check("t1_resp", bus.icache_resp, 1'b1);
    check("t1_rdata", bus.icache_rdata, rd);
    check("t1_dresp", bus.dcache_resp, 1'b0);
    tick();
    bus.icache_read = 0; bus.mem_resp = 0;
    #1;
    check("t1_done_rd", bus.mem_read, 1'b0);
    check("t1_done_resp", bus.icache_resp, 1'b0);

    // 2. Simultaneous I read and D write: D first, then I
    bus.icache_read = 1; bus.icache_address = 32'h100;
    bus.dcache_write = 1; bus.dcache_address = 32'h200; bus.dcache_wdata = w1;
    tick();
    check("t2_wr", bus.mem_write, 1'b1);
    check("t2_rd", bus.mem_read, 1'b0);
    check("t2_addr", bus.mem_address, 32'h200);
    check("t2_wdata", bus.mem_wdata, w1);
    bus.mem_resp = 1;
    #1;
    check("t2_dresp", bus.dcache_resp, 1'b1);
    check("t2_iresp0", bus.icache_resp, 1'b0);
    tick();
    bus.mem_resp = 0; bus.dcache_write = 0;
    #1;
    check("t2_dead", bus.mem_read | bus.mem_write, 1'b0);
    check("t2_streak", dut.streak, 1);
    serve("t2_i", 1'b1, 32'h100, {8{32'h0000_0100}});
    bus.icache_read = 0;
    check("t2_streak0", dut.streak, 0);

    // 3. Starvation bound: I held, D reads back to back -> D,D,D,D,I,D
    bus.icache_read = 1; bus.icache_address = 32'h300;
    bus.dcache_read = 1;
    for (int k = 0; k < 6; k++) begin
      bus.dcache_address = 32'h400 + 32'(k) * 32'h20;
      if (k == 4) check("t3_streak_max", dut.streak, 4);
      serve("t3", (k == 4), (k == 4) ? 32'h300 : 32'h400 + 32'(k) * 32'h20,
            {8{32'hA5A5_0000 + 32'(k)}});
      if (k == 4) check("t3_streak_zero", dut.streak, 0);
    end
    bus.icache_read = 0; bus.dcache_read = 0;

    // 4. Both D strobes -> write; latched values hold against input changes
    bus.dcache_read = 1; bus.dcache_write = 1;
    bus.dcache_address = 32'h500; bus.dcache_wdata = w2;
    tick();
    check("t4_wr", bus.mem_write, 1'b1);
    check("t4_rd", bus.mem_read, 1'b0);
    bus.dcache_address = 32'h600; bus.dcache_wdata = w3; bus.dcache_read = 0;
    tick();
    check("t4_addr_hold", bus.mem_address, 32'h500);
    check("t4_wdata_hold", bus.mem_wdata, w2);
    check("t4_wr_hold", bus.mem_write, 1'b1);
    bus.mem_resp = 1;
    #1;
    check("t4_dresp", bus.dcache_resp, 1'b1);
    tick();
    bus.mem_resp = 0; bus.dcache_write = 0;
    #1;

    // 5. Reset in the middle of a writeback
    bus.icache_read = 1; bus.icache_address = 32'h700;
    bus.dcache_write = 1; bus.dcache_address = 32'h800; bus.dcache_wdata = w1;
    tick();
    check("t5_wr", bus.mem_write, 1'b1);
    check("t5_streak1", dut.streak, 1);
    rst = 0;
    tick();
    check("t5_rd", bus.mem_read, 1'b0);
    check("t5_wr0", bus.mem_write, 1'b0);
    check("t5_addr", bus.mem_address, 32'h0);
    check("t5_wdata", bus.mem_wdata, 256'h0);
    check("t5_dresp", bus.dcache_resp, 1'b0);
    check("t5_streak", dut.streak, 0);
    check("t5_state", dut.state, 0);
    bus.icache_read = 0; bus.dcache_write = 0;
    rst = 1;
    tick();

    // 6. Spurious resp in IDLE, then requester drops mid-transaction
    bus.mem_resp = 1; bus.mem_rdata = w3;
    #1;
    check("t6_spur_i", bus.icache_resp, 1'b0);
    check("t6_spur_d", bus.dcache_resp, 1'b0);
    tick();
    bus.mem_resp = 0;
    check("t6_spur_idle", bus.mem_read | bus.mem_write, 1'b0);
    bus.dcache_read = 1; bus.dcache_address = 32'h900;
    tick();
    bus.dcache_read = 0;
    tick();
    check("t6_drop_rd", bus.mem_read, 1'b1);
    check("t6_drop_addr", bus.mem_address, 32'h900);
    bus.mem_rdata = w2; bus.mem_resp = 1;
    #1;
    check("t6_drop_resp", bus.dcache_resp, 1'b1);
    check("t6_drop_rdata", bus.dcache_rdata, w2);
    tick();
    bus.mem_resp = 0;
    #1;
    check("t6_end_idle", bus.mem_read | bus.mem_write, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
